// File: rtl/vx_scatter_unit_pkg.sv
// Shared configuration, instruction header type and packet-id helpers for the
// scatter/gather pair.
package vx_scatter_unit_pkg;

  localparam int XLEN        = 32;
  localparam int NUM_THREADS = 16;
  localparam int SIMD_WIDTH  = 8;
  localparam int ISSUE_WIDTH = 4;
  localparam int NUM_SRCS    = 3;
  localparam int SIMD_COUNT  = NUM_THREADS / SIMD_WIDTH;
  localparam int SID_W       = (SIMD_COUNT > 1) ? $clog2(SIMD_COUNT) : 1;
  localparam int LPID_MAX_W  = (SIMD_WIDTH > 1) ? $clog2(SIMD_WIDTH) : 1;
  localparam int PID_MAX_W   = SID_W + LPID_MAX_W;

  typedef struct packed {
    logic [7:0]       uuid;
    logic [1:0]       wid;
    logic [SID_W-1:0] sid;
    logic [XLEN-1:0]  pc;
    logic [3:0]       op_type;
    logic [7:0]       op_args;
    logic             wb;
    logic [4:0]       rd;
  } instr_hdr_t;

  function automatic int num_packets(input int lanes);
    return SIMD_WIDTH / lanes;
  endfunction

  function automatic int lpid_bits(input int lanes);
    return $clog2(SIMD_WIDTH / lanes);
  endfunction

  function automatic int lpid_w(input int lanes);
    return (lpid_bits(lanes) > 0) ? lpid_bits(lanes) : 1;
  endfunction

  function automatic int pid_w(input int lanes);
    return (SIMD_COUNT > 1) ? SID_W + lpid_w(lanes) : lpid_w(lanes);
  endfunction

  // The gather stage decodes this as {sid, lpid} to place results at lpid*lanes.
  function automatic logic [PID_MAX_W-1:0] pack_pid(input logic [SID_W-1:0] sid,
                                                    input int unsigned    lpid,
                                                    input int             lanes);
    logic [PID_MAX_W-1:0] pid;
    pid = PID_MAX_W'(lpid);
    if (SIMD_COUNT > 1) pid = pid | (PID_MAX_W'(sid) << lpid_w(lanes));
    return pid;
  endfunction

endpackage

// File: rtl/vx_scatter_unit_if.sv
// Full-width dispatch bus (all issue slots) and per-block execute packet bus.
interface vx_dispatch_if import vx_scatter_unit_pkg::*; #(
  parameter int N = ISSUE_WIDTH
) ();
  logic [N-1:0]                                       valid;
  logic [N-1:0]                                       ready;
  instr_hdr_t [N-1:0]                                 hdr;
  logic [N-1:0][SIMD_WIDTH-1:0]                       tmask;
  logic [N-1:0][NUM_SRCS-1:0][SIMD_WIDTH-1:0][XLEN-1:0] rs_data;

  modport master (output valid, hdr, tmask, rs_data, input ready);
  modport slave  (input valid, hdr, tmask, rs_data, output ready);
endinterface

interface vx_execute_if import vx_scatter_unit_pkg::*; #(
  parameter int N = 1,
  parameter int L = 1
) ();
  localparam int PID_W = pid_w(L);

  logic [N-1:0]                              valid;
  logic [N-1:0]                              ready;
  instr_hdr_t [N-1:0]                        hdr;
  logic [N-1:0][L-1:0]                       tmask;
  logic [N-1:0][NUM_SRCS-1:0][L-1:0][XLEN-1:0] rs_data;
  logic [N-1:0][PID_W-1:0]                   pid;
  logic [N-1:0]                              sop;
  logic [N-1:0]                              eop;

  modport master (output valid, hdr, tmask, rs_data, pid, sop, eop, input ready);
  modport slave  (input valid, hdr, tmask, rs_data, pid, sop, eop, output ready);
endinterface

// File: rtl/vx_scatter_unit_slicer.sv
// One block: round-robin pick among its issue slots, then walk the nonempty
// packets of the granted instruction lowest-first.
//   state | meaning
//   IDLE  | no instruction locked; grant follows the round-robin pick
//   BUSY  | grant locked on lock_idx until its eop packet is accepted
module vx_scatter_unit_slicer import vx_scatter_unit_pkg::*; #(
  parameter int K       = 1,
  parameter int L       = 1,
  parameter int OUT_BUF = 0,
  parameter int PID_W   = pid_w(L)
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [K-1:0]                                  in_valid,
  output logic [K-1:0]                                  in_ready,
  input  instr_hdr_t [K-1:0]                            in_hdr,
  input  logic [K-1:0][SIMD_WIDTH-1:0]                  in_tmask,
  input  logic [K-1:0][NUM_SRCS-1:0][SIMD_WIDTH-1:0][XLEN-1:0] in_data,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output instr_hdr_t                                    out_hdr,
  output logic [L-1:0]                                  out_tmask,
  output logic [NUM_SRCS-1:0][L-1:0][XLEN-1:0]          out_data,
  output logic [PID_W-1:0]                              out_pid,
  output logic                                          out_sop,
  output logic                                          out_eop
);
  localparam int NP     = num_packets(L);
  localparam int IDX_W  = (K > 1) ? $clog2(K) : 1;
  localparam int LP_W   = lpid_w(L);
  localparam int LANE_W = $clog2(SIMD_WIDTH);

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    instr_hdr_t                          hdr;
    logic [L-1:0]                        tmask;
    logic [NUM_SRCS-1:0][L-1:0][XLEN-1:0] data;
    logic [PID_W-1:0]                    pid;
    logic                                sop;
    logic                                eop;
  } pkt_t;

  state_t            state;
  logic [IDX_W-1:0]  ptr, lock_idx, rr_idx, sel, sel_next, cand;
  logic              rr_hit;
  logic [NP-1:0]     sent, nonempty, remaining, cur_bit;
  logic [LP_W-1:0]   cur;
  logic [LANE_W-1:0] base;
  pkt_t              pkt, out_pkt;
  logic              pkt_valid, pkt_ready, fire;

  always_comb begin
    int j;
    j      = 0;
    cand   = '0;
    rr_idx = ptr;
    rr_hit = 1'b0;
    for (int i = 0; i < K; i++) begin
      j = int'(ptr) + i;
      if (j >= K) j = j - K;
      cand = IDX_W'(j);
      if (!rr_hit && in_valid[cand]) begin
        rr_idx = cand;
        rr_hit = 1'b1;
      end
    end
  end

  assign sel      = (state == BUSY) ? lock_idx : rr_idx;
  assign sel_next = (sel == IDX_W'(K - 1)) ? '0 : sel + IDX_W'(1);

  for (genvar p = 0; p < NP; p++) begin : g_nonempty
    assign nonempty[p] = |in_tmask[sel][p*L +: L];
  end

  assign remaining = nonempty & ~sent;

  always_comb begin
    cur = '0;
    for (int p = NP - 1; p >= 0; p--) begin
      if (remaining[p]) cur = LP_W'(p);
    end
  end

  assign cur_bit = NP'(1) << cur;
  assign base    = LANE_W'(int'(cur) * L);

  // An all-zero tmask still yields one packet: cur=0, nothing remains, so eop.
  always_comb begin
    pkt       = '0;
    pkt.hdr   = in_hdr[sel];
    pkt.tmask = in_tmask[sel][base +: L];
    for (int s = 0; s < NUM_SRCS; s++) begin
      pkt.data[s] = in_data[sel][s][base +: L];
    end
    pkt.pid = PID_W'(pack_pid(in_hdr[sel].sid, int'(cur), L));
    pkt.sop = (sent == '0);
    pkt.eop = ((remaining & ~cur_bit) == '0);
  end

  assign pkt_valid = in_valid[sel];
  assign fire      = pkt_valid && pkt_ready;

  always_comb begin
    for (int k = 0; k < K; k++) begin
      in_ready[k] = fire && pkt.eop && (sel == IDX_W'(k));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sent     <= '0;
      ptr      <= '0;
      lock_idx <= '0;
    end else begin
      case (state)
        IDLE: if (pkt_valid) begin
          lock_idx <= sel;
          if (fire && pkt.eop) begin
            ptr <= sel_next;
          end else begin
            state <= BUSY;
            if (fire) sent <= sent | cur_bit;
          end
        end
        BUSY: if (fire) begin
          if (pkt.eop) begin
            state <= IDLE;
            sent  <= '0;
            ptr   <= sel_next;
          end else begin
            sent <= sent | cur_bit;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  if (OUT_BUF == 0) begin : g_direct
    assign pkt_ready = out_ready;
    assign out_valid = pkt_valid;
    assign out_pkt   = pkt;
  end else begin : g_reg
    logic buf_valid;
    pkt_t buf_pkt;
    assign pkt_ready = !buf_valid || out_ready;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        buf_valid <= 1'b0;
        buf_pkt   <= '0;
      end else if (pkt_ready) begin
        buf_valid <= pkt_valid;
        buf_pkt   <= pkt;
      end
    end
    assign out_valid = buf_valid;
    assign out_pkt   = buf_pkt;
  end

  assign out_hdr   = out_pkt.hdr;
  assign out_tmask = out_pkt.tmask;
  assign out_data  = out_pkt.data;
  assign out_pid   = out_pkt.pid;
  assign out_sop   = out_pkt.sop;
  assign out_eop   = out_pkt.eop;

endmodule

// File: rtl/vx_scatter_unit.sv
// Splits full-width dispatched instructions into NUM_LANES-wide packets and
// routes issue slot i to functional-unit block i % BLOCK_SIZE.
module vx_scatter_unit import vx_scatter_unit_pkg::*; #(
  parameter int BLOCK_SIZE = 1,
  parameter int NUM_LANES  = 1,
  parameter int OUT_BUF    = 0
) (
  input logic           clk,
  input logic           reset,
  vx_dispatch_if.slave  dispatch_if,
  vx_execute_if.master  execute_if
);
  localparam int K = ISSUE_WIDTH / BLOCK_SIZE;

  if (ISSUE_WIDTH % BLOCK_SIZE != 0) begin : g_bad_block_size
    $error("ISSUE_WIDTH must be a multiple of BLOCK_SIZE");
  end
  if (SIMD_WIDTH % NUM_LANES != 0) begin : g_bad_num_lanes
    $error("SIMD_WIDTH must be a multiple of NUM_LANES");
  end

  for (genvar b = 0; b < BLOCK_SIZE; b++) begin : g_block
    logic [K-1:0]                                       cand_valid, cand_ready;
    instr_hdr_t [K-1:0]                                 cand_hdr;
    logic [K-1:0][SIMD_WIDTH-1:0]                       cand_tmask;
    logic [K-1:0][NUM_SRCS-1:0][SIMD_WIDTH-1:0][XLEN-1:0] cand_data;

    for (genvar k = 0; k < K; k++) begin : g_cand
      localparam int SLOT = k * BLOCK_SIZE + b;
      assign cand_valid[k]          = dispatch_if.valid[SLOT];
      assign cand_hdr[k]            = dispatch_if.hdr[SLOT];
      assign cand_tmask[k]          = dispatch_if.tmask[SLOT];
      assign cand_data[k]           = dispatch_if.rs_data[SLOT];
      assign dispatch_if.ready[SLOT] = cand_ready[k];
    end

    vx_scatter_unit_slicer #(
      .K       (K),
      .L       (NUM_LANES),
      .OUT_BUF (OUT_BUF)
    ) u_slicer (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (cand_valid),
      .in_ready  (cand_ready),
      .in_hdr    (cand_hdr),
      .in_tmask  (cand_tmask),
      .in_data   (cand_data),
      .out_valid (execute_if.valid[b]),
      .out_ready (execute_if.ready[b]),
      .out_hdr   (execute_if.hdr[b]),
      .out_tmask (execute_if.tmask[b]),
      .out_data  (execute_if.rs_data[b]),
      .out_pid   (execute_if.pid[b]),
      .out_sop   (execute_if.sop[b]),
      .out_eop   (execute_if.eop[b])
    );
  end

endmodule

// File: tb/tb_vx_scatter_unit.sv
// Directed bench: SIMD_WIDTH=8, NUM_LANES=2, ISSUE_WIDTH=4, BLOCK_SIZE=2.
module tb_vx_scatter_unit;
  import vx_scatter_unit_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  vx_dispatch_if #(.N(ISSUE_WIDTH)) dif ();
  vx_execute_if  #(.N(2), .L(2))    eif ();

  vx_scatter_unit #(
    .BLOCK_SIZE (2),
    .NUM_LANES  (2),
    .OUT_BUF    (0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .dispatch_if (dif),
    .execute_if  (eif)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dval(input int s, input int r, input int t);
    return 32'(s * 32'h0100_0000 + r * 32'h0001_0000 + t);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int s, input logic [7:0] uuid, input logic [7:0] tm, input logic sid);
    dif.valid[s]       = 1'b1;
    dif.hdr[s]         = '0;
    dif.hdr[s].uuid    = uuid;
    dif.hdr[s].sid     = sid;
    dif.hdr[s].pc      = 32'h1000 + 32'(s);
    dif.tmask[s]       = tm;
    for (int r = 0; r < NUM_SRCS; r++)
      for (int t = 0; t < SIMD_WIDTH; t++)
        dif.rs_data[s][r][t] = dval(s, r, t);
  endtask

  task automatic expect_pkt(input int b, input string tag, input int pid, input logic [1:0] tm,
                            input logic sop, input logic eop, input logic [7:0] uuid);
    chk({tag, ".valid"}, eif.valid[b], 1);
    chk({tag, ".pid"},   eif.pid[b], pid);
    chk({tag, ".tmask"}, eif.tmask[b], tm);
    chk({tag, ".sop"},   eif.sop[b], sop);
    chk({tag, ".eop"},   eif.eop[b], eop);
    chk({tag, ".uuid"},  eif.hdr[b].uuid, uuid);
  endtask

  initial begin
    dif.valid   = '0;
    dif.hdr     = '0;
    dif.tmask   = '0;
    dif.rs_data = '0;
    eif.ready   = '1;

    repeat (2) @(negedge clk);
    chk("rst.exec_valid", eif.valid, 0);
    chk("rst.disp_ready", dif.ready, 0);
    step();
    reset = 1'b0;

    // full mask on slot 0
    load(0, 8'h11, 8'hFF, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      expect_pkt(0, "full", c, 2'b11, c == 0, c == 3, 8'h11);
      chk("full.ready", dif.ready[0], c == 3);
      if (c == 2) chk("full.data", eif.rs_data[0][0][0], dval(0, 0, 4));
      step();
    end
    dif.valid[0] = 1'b0;
    @(negedge clk);
    chk("full.idle", eif.valid[0], 0);

    // sparse mask: only lanes 4-5
    step();
    load(0, 8'h12, 8'h30, 1'b0);
    @(negedge clk);
    expect_pkt(0, "sparse", 2, 2'b11, 1, 1, 8'h12);
    chk("sparse.ready", dif.ready, 4'b0001);
    chk("sparse.d0", eif.rs_data[0][0][0], dval(0, 0, 4));
    chk("sparse.d1", eif.rs_data[0][0][1], dval(0, 0, 5));
    chk("sparse.rs3", eif.rs_data[0][2][1], dval(0, 2, 5));
    step();
    dif.valid[0] = 1'b0;

    // empty mask on slot 2 with sid=1: pid = {1, 00}
    load(2, 8'h13, 8'h00, 1'b1);
    @(negedge clk);
    expect_pkt(0, "empty", 4, 2'b00, 1, 1, 8'h13);
    chk("empty.ready", dif.ready, 4'b0100);
    step();
    dif.valid[2] = 1'b0;

    // arbitration: both blocks busy, slot 0 re-presents while slot 2 waits
    load(0, 8'h21, 8'h0F, 1'b0);
    load(2, 8'h22, 8'h0F, 1'b0);
    load(1, 8'h31, 8'h0F, 1'b0);
    load(3, 8'h32, 8'h0F, 1'b0);
    @(negedge clk);
    expect_pkt(0, "arb.b0c1", 0, 2'b11, 1, 0, 8'h21);
    expect_pkt(1, "arb.b1c1", 0, 2'b11, 1, 0, 8'h31);
    chk("arb.ready1", dif.ready, 4'b0000);
    step();
    @(negedge clk);
    expect_pkt(0, "arb.b0c2", 1, 2'b11, 0, 1, 8'h21);
    expect_pkt(1, "arb.b1c2", 1, 2'b11, 0, 1, 8'h31);
    chk("arb.ready2", dif.ready, 4'b0011);
    step();
    load(0, 8'h23, 8'h03, 1'b0);
    dif.valid[1] = 1'b0;
    @(negedge clk);
    expect_pkt(0, "arb.b0c3", 0, 2'b11, 1, 0, 8'h22);
    expect_pkt(1, "arb.b1c3", 0, 2'b11, 1, 0, 8'h32);
    step();
    @(negedge clk);
    expect_pkt(0, "arb.b0c4", 1, 2'b11, 0, 1, 8'h22);
    expect_pkt(1, "arb.b1c4", 1, 2'b11, 0, 1, 8'h32);
    chk("arb.ready4", dif.ready, 4'b1100);
    step();
    dif.valid[2] = 1'b0;
    dif.valid[3] = 1'b0;
    @(negedge clk);
    expect_pkt(0, "arb.b0c5", 0, 2'b11, 1, 1, 8'h23);
    chk("arb.ready5", dif.ready, 4'b0001);
    chk("arb.b1idle", eif.valid[1], 0);
    step();
    dif.valid[0] = 1'b0;

    // backpressure: pid1 held for 3 cycles
    load(0, 8'h41, 8'hFF, 1'b0);
    @(negedge clk);
    expect_pkt(0, "bp.p0", 0, 2'b11, 1, 0, 8'h41);
    step();
    eif.ready[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      expect_pkt(0, "bp.hold", 1, 2'b11, 0, 0, 8'h41);
      chk("bp.hold.ready", dif.ready[0], 0);
      step();
    end
    eif.ready[0] = 1'b1;
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      expect_pkt(0, "bp.run", c, 2'b11, 0, c == 3, 8'h41);
      chk("bp.run.ready", dif.ready[0], c == 3);
      step();
    end
    dif.valid[0] = 1'b0;

    // reset after pid1 has been accepted
    load(0, 8'h51, 8'hFF, 1'b0);
    @(negedge clk);
    expect_pkt(0, "rstm.p0", 0, 2'b11, 1, 0, 8'h51);
    step();
    @(negedge clk);
    expect_pkt(0, "rstm.p1", 1, 2'b11, 0, 0, 8'h51);
    step();
    reset     = 1'b1;
    dif.valid = '0;
    @(negedge clk);
    chk("rstm.valid", eif.valid, 0);
    chk("rstm.ready", dif.ready, 0);
    step();
    reset = 1'b0;
    load(0, 8'h52, 8'hFF, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      expect_pkt(0, "rstm.fresh", c, 2'b11, c == 0, c == 3, 8'h52);
      step();
    end
    dif.valid[0] = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_scatter_unit.md
# VX_scatter_unit

Splits each full-width dispatched instruction into NUM_LANES-wide execution packets and routes them to BLOCK_SIZE functional-unit lanes. It is the transmit-side counterpart of the per-unit gather stage, which reassembles those packets into commits. It sits between the operand collector/dispatch stage and each functional unit (ALU, FPU, LSU, SFU). It emits pid/sop/eop so the gather stage can place results back at `lpid*NUM_LANES`.

## Interface
- BLOCK_SIZE, 1, number of functional-unit blocks; `ISSUE_WIDTH % BLOCK_SIZE == 0` (static assert)
- NUM_LANES, 1, lanes per packet; `SIMD_WIDTH % NUM_LANES == 0` (static assert)
- OUT_BUF, 0, output elastic-buffer config, encoded per `TO_OUT_BUF_SIZE`/`TO_OUT_BUF_REG`
- clk  input  1  single clock
- reset  input  1  asynchronous, active-high
- dispatch_if  slave  VX_dispatch_if[ISSUE_WIDTH]  full-width instruction: uuid, wid, sid, tmask[SIMD_WIDTH], PC, op_type, op_args, wb, rd, rs1/rs2/rs3 data[SIMD_WIDTH][XLEN]
- execute_if  master  VX_execute_if#(NUM_LANES)[BLOCK_SIZE]  packet: same scalar fields, tmask[NUM_LANES], rsN data[NUM_LANES][XLEN], pid, sop, eop

## Operation
- Slot mapping: issue slot i feeds block `i % BLOCK_SIZE`, so each block has `ISSUE_WIDTH/BLOCK_SIZE` candidates. This is the inverse of the gather stage's low-bit isw encoding.
- Per block, a round-robin arbiter picks one valid candidate. The grant is locked until that instruction's eop packet handshakes.
- NUM_PACKETS = SIMD_WIDTH/NUM_LANES; LPID_BITS = CLOG2(NUM_PACKETS).
- Packet p is nonempty iff `tmask[p*NUM_LANES +: NUM_LANES] != 0`.
- Per-block FSM:
  - IDLE: on a granted valid, emit the first nonempty packet and go to BUSY unless it is also the last.
  - BUSY: advance to the next nonempty packet each output handshake. Return to IDLE on the eop handshake.
- Sent-mask register: records packets already emitted. Next packet = lowest set bit of (nonempty & ~sent), via priority encoder.
- sop=1 on the first emitted packet only. eop=1 when no nonempty packets remain after the current one.
- Empty tmask: emit one packet, pid lpid=0, tmask=0, sop=eop=1.
- pid = {sid, lpid} when SIMD_COUNT>1; otherwise pid = lpid.
- LPID_BITS==0: pure passthrough with sop=eop=1, no FSM.
- dispatch_if[i].ready is asserted only in the cycle the granted instruction's eop packet is accepted by the output buffer. The input is held stable by the valid/ready protocol, so no operand latching is needed.
- Reset values: FSM=IDLE, sent mask=0, arbiter pointer=slot 0, all execute_if.valid=0, all dispatch_if.ready=0.

## Timing
- OUT_BUF=0: packet valid combinationally in the cycle the grant is made.
- OUT_BUF register modes add 1 cycle latency.
- Throughput: one packet per cycle per block with no bubbles between consecutive instructions. k nonempty packets occupy the block for exactly k accepted cycles.
- Backpressure: if execute_if.ready=0, the current packet, sent mask and grant hold unchanged.
- A new valid on a non-granted slot mid-instruction waits. The arbiter advances only after eop.
- Simultaneous eop handshake and new candidates: re-arbitrate the same cycle; the pointer moves past the finished slot.
- Reset mid-instruction: the remaining packets are dropped, the FSM returns to IDLE and the buffers empty. Upstream is reset concurrently.

## Structure
- The following belong in VX_gpu_pkg: NUM_PACKETS/LPID width helpers and the pid packing function. This keeps them shared with the gather stage.
- Natural sub-module: VX_scatter_slicer, one instance per block. It contains the sent mask, priority encoder, FSM and the packet data mux.
- Arbiter: VX_generic_arbiter (round-robin).
- Output stage: VX_elastic_buffer per block.

## Test plan
- Bench config: SIMD_WIDTH=8, NUM_LANES=2, ISSUE_WIDTH=4, BLOCK_SIZE=2.
- **Full mask:** tmask=0xFF on slot 0 → block 0 emits pids 0,1,2,3 on 4 consecutive cycles. sop only on pid0, eop only on pid3. Slot 0 ready pulses once, in cycle 4.
- **Sparse mask:** tmask=0x30 → single packet pid 2, tmask=2'b11, sop=eop=1, data lanes 4–5.
- **Empty mask:** tmask=0x00 → one packet pid 0, tmask=0, sop=eop=1.
- **Arbitration:** slots 0 and 2 both valid with tmask=0x0F → block 0 serves slot 0 (pids 0,1) and then slot 2 (pids 0,1) back-to-back with no idle cycle. Slots 1 and 3 proceed independently on block 1.
- **Backpressure:** hold execute_if[0].ready=0 for 3 cycles mid-instruction → the same packet is held stable and none are skipped or duplicated.
- **Reset mid-instruction:** assert reset after pid1 of tmask=0xFF → valid drops immediately. After release, the FSM is IDLE and a fresh instruction starts at pid0 with sop=1.
